// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel scheduled output multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED       = 1'b0;
    localparam logic MODE_ROUND_ROBIN = 1'b1;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr, wrapping modulo N_CH.
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt_oh,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any_valid
);

    int               idx_int;
    logic [SEL_W-1:0] idx;
    logic             found;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx_int = 0;
        idx     = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx_int = int'(ptr) + i;
            if (idx_int >= N_CH) idx_int = idx_int - N_CH;
            idx = SEL_W'(idx_int);
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt_idx     = idx;
                gnt_oh[idx] = 1'b1;
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/mux_sched_nw.sv
// N-channel registered multiplexer with fixed or round-robin selection and a valid/ready output.
module mux_sched_nw
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic              inClk,
    input  logic              inRst,
    input  logic [N_CH*W-1:0] inData,
    input  logic [N_CH-1:0]   inValid,
    output logic [N_CH-1:0]   outAck,
    input  logic              inMode,
    input  logic [SEL_W-1:0]  inSel,
    input  logic              inSelLoad,
    output logic              outSelErr,
    output logic [W-1:0]      outData,
    output logic [SEL_W-1:0]  outCh,
    output logic              outValid,
    input  logic              inReady
);

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;

    logic [W-1:0]     ch_data [N_CH];
    logic [N_CH-1:0]  rr_gnt_oh;
    logic [SEL_W-1:0] rr_gnt_idx;
    logic             rr_any;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             cap;
    logic             sel_ok;

    rr_arbiter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_rr (
        .req       (inValid),
        .ptr       (rr_ptr_q),
        .gnt_oh    (rr_gnt_oh),
        .gnt_idx   (rr_gnt_idx),
        .any_valid (rr_any)
    );

    always_comb begin
        for (int k = 0; k < N_CH; k++) ch_data[k] = inData[k*W +: W];
    end

    always_comb begin
        if (inMode == MODE_ROUND_ROBIN) begin
            grant       = rr_gnt_idx;
            grant_valid = rr_any;
        end else begin
            grant       = sel_q;
            grant_valid = inValid[sel_q];
        end
        cap    = grant_valid && (!out_valid_q || inReady);
        sel_ok = int'(inSel) < N_CH;
    end

    // Acknowledge is masked during reset because the capture it reports will not happen.
    assign outAck = (cap && !inRst) ? (N_CH'(1) << grant) : '0;

    always_comb begin
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        sel_err_d   = inSelLoad && !sel_ok;

        if (cap) begin
            out_data_d  = ch_data[grant];
            out_ch_d    = grant;
            out_valid_d = 1'b1;
            if (inMode == MODE_ROUND_ROBIN) rr_ptr_d = SEL_W'(wrap_inc(int'(grant), N_CH));
        end else if (out_valid_q && inReady) begin
            out_valid_d = 1'b0;
        end

        // A software preset overrides the round-robin advance taken in the same cycle.
        if (inSelLoad && sel_ok) begin
            sel_d    = inSel;
            rr_ptr_d = inSel;
        end
    end

    // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
    // NOTE: the data register is reset too, since a reset must leave outData observably zero.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            sel_q       <= '0;
            rr_ptr_q    <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign outData   = out_data_q;
    assign outCh     = out_ch_q;
    assign outValid  = out_valid_q;
    assign outSelErr = sel_err_q;

endmodule

// File: tb/tb_mux_sched_nw.sv
// Scoreboard bench: expected words queued at stimulus time, popped on each output handshake.
module tb_mux_sched_nw;
    import mux_pkg::*;

    logic        clk = 1'b0;
    logic        in_rst, in_mode, in_sel_load, in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_valid, out_ack;
    logic [1:0]  in_sel, out_ch;
    logic [3:0]  out_data;
    logic        out_sel_err, out_valid;

    logic        d3_rst, d3_sel_load, d3_sel_err, d3_valid_o;
    logic [11:0] d3_data;
    logic [2:0]  d3_valid, d3_ack;
    logic [1:0]  d3_sel, d3_ch;
    logic [3:0]  d3_out;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [5:0] sb [$];

    always #5 clk = ~clk;

    mux_sched_nw #(.N_CH(4), .W(4)) dut (
        .inClk(clk), .inRst(in_rst), .inData(in_data), .inValid(in_valid), .outAck(out_ack),
        .inMode(in_mode), .inSel(in_sel), .inSelLoad(in_sel_load), .outSelErr(out_sel_err),
        .outData(out_data), .outCh(out_ch), .outValid(out_valid), .inReady(in_ready)
    );

    mux_sched_nw #(.N_CH(3), .W(4)) dut3 (
        .inClk(clk), .inRst(d3_rst), .inData(d3_data), .inValid(d3_valid), .outAck(d3_ack),
        .inMode(MODE_FIXED), .inSel(d3_sel), .inSelLoad(d3_sel_load), .outSelErr(d3_sel_err),
        .outData(d3_out), .outCh(d3_ch), .outValid(d3_valid_o), .inReady(1'b1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] data, input logic [1:0] ch);
        sb.push_back({ch, data});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!in_rst && out_valid && in_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_word", {26'd0, out_ch, out_data}, 32'hFFFF_FFFF);
            end else begin
                logic [5:0] e;
                e = sb.pop_front();
                check("sb_data", {28'd0, out_data}, {28'd0, e[3:0]});
                check("sb_ch", {30'd0, out_ch}, {30'd0, e[5:4]});
            end
        end
    end

    initial begin
        in_rst = 1'b1; in_mode = MODE_ROUND_ROBIN; in_valid = 4'b1111; in_ready = 1'b1;
        in_data = 16'h4321; in_sel = 2'd0; in_sel_load = 1'b0;
        d3_rst = 1'b1; d3_sel_load = 1'b0; d3_sel = 2'd0; d3_valid = 3'b000; d3_data = 12'h000;

        cyc();
        @(negedge clk);
        check("rst_ack_masked", {28'd0, out_ack}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {28'd0, out_data}, 32'd0);
        check("rst_ch", {30'd0, out_ch}, 32'd0);
        check("rst_selerr", {31'd0, out_sel_err}, 32'd0);
        cyc();

        // FIXED: load channel 2, capture, then hold under backpressure.
        in_rst = 1'b0; in_mode = MODE_FIXED; in_valid = 4'b0000; in_sel = 2'd2; in_sel_load = 1'b1;
        cyc();
        in_sel_load = 1'b0; in_data = 16'h0A00; in_valid = 4'b0100;
        @(negedge clk);
        check("fixed_ack", {28'd0, out_ack}, 32'b0100);
        push(4'hA, 2'd2);
        cyc();
        in_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_ack", {28'd0, out_ack}, 32'd0);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_data", {28'd0, out_data}, 32'hA);
            check("bp_ch", {30'd0, out_ch}, 32'd2);
            cyc();
        end
        in_ready = 1'b1; in_data = 16'h0500;
        @(negedge clk);
        check("bp_release_ack", {28'd0, out_ack}, 32'b0100);
        push(4'h5, 2'd2);
        cyc();
        in_valid = 4'b0000;
        @(negedge clk);
        check("drain_ack", {28'd0, out_ack}, 32'd0);
        cyc();
        @(negedge clk);
        check("drained_valid", {31'd0, out_valid}, 32'd0);
        cyc();

        // ROUND_ROBIN over all channels from pointer 0.
        in_sel = 2'd0; in_sel_load = 1'b1;
        cyc();
        in_sel_load = 1'b0; in_mode = MODE_ROUND_ROBIN; in_valid = 4'b1111; in_data = 16'h4321;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] k;
            k = 2'(i % 4);
            @(negedge clk);
            check("rr_all_ack", {28'd0, out_ack}, 32'(4'b0001 << k));
            push(4'(k + 1), k);
            cyc();
        end
        in_valid = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            cyc();
        end

        // ROUND_ROBIN with channels 1 and 3 only; pointer starts at 1.
        in_valid = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] k;
            k = (i % 2 == 0) ? 2'd1 : 2'd3;
            @(negedge clk);
            check("rr_sparse_ack", {28'd0, out_ack}, 32'(4'b0001 << k));
            push(4'(k + 1), k);
            cyc();
        end
        in_valid = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            cyc();
        end

        // Reset mid-transfer: pointer is 2, capture ch2, then reset under backpressure.
        in_valid = 4'b0100; in_data = 16'h0300;
        @(negedge clk);
        check("pre_rst_ack", {28'd0, out_ack}, 32'b0100);
        cyc();
        in_ready = 1'b0; in_rst = 1'b1; in_valid = 4'b1111;
        @(negedge clk);
        check("held_before_rst", {26'd0, out_ch, out_data}, {26'd0, 2'd2, 4'h3});
        check("ack_during_rst", {28'd0, out_ack}, 32'd0);
        cyc();
        in_rst = 1'b0; in_valid = 4'b0000;
        @(negedge clk);
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_data", {28'd0, out_data}, 32'd0);
        check("post_rst_ch", {30'd0, out_ch}, 32'd0);
        cyc();
        in_valid = 4'b1111; in_data = 16'h4321; in_ready = 1'b1;
        @(negedge clk);
        check("rr_restart_ack", {28'd0, out_ack}, 32'b0001);
        push(4'h1, 2'd0);
        cyc();
        in_valid = 4'b0000;
        @(negedge clk);
        cyc();

        // N_CH=3: out-of-range select load raises one error pulse and changes nothing.
        d3_rst = 1'b0; d3_sel = 2'd1; d3_sel_load = 1'b1;
        cyc();
        d3_sel = 2'd3; d3_valid = 3'b010; d3_data = 12'h070;
        @(negedge clk);
        check("n3_ack", {29'd0, d3_ack}, 32'b010);
        check("n3_err_idle", {31'd0, d3_sel_err}, 32'd0);
        cyc();
        d3_sel_load = 1'b0; d3_data = 12'h090;
        @(negedge clk);
        check("n3_err_pulse", {31'd0, d3_sel_err}, 32'd1);
        check("n3_ack_sel_kept", {29'd0, d3_ack}, 32'b010);
        check("n3_out", {25'd0, d3_valid_o, d3_ch, d3_out}, {25'd0, 1'b1, 2'd1, 4'h7});
        cyc();
        d3_valid = 3'b000;
        @(negedge clk);
        check("n3_err_cleared", {31'd0, d3_sel_err}, 32'd0);
        check("n3_out2", {26'd0, d3_ch, d3_out}, {26'd0, 2'd1, 4'h9});
        cyc();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_sched_nw.md
# mux_sched_nw

Parametrised N-channel, W-bit registered multiplexer with a valid/ready output handshake and two selection modes: fixed (software-loaded select) and round-robin scan over valid channels. It generalises the fixed 4:1 × 4-bit combinational mux of the baseband datapath. It sits between the per-channel chip/symbol sources and the single downstream consumer (spreader/modulator path), with one registered output stage and per-channel consume acknowledges.

## Interface
- N_CH, default 4: number of input channels (≥2)
- W, default 4: data width per channel (≥1)
- SEL_W, default $clog2(N_CH): select/channel-index width (derived, not overridden)

Ports (one clock; reset is synchronous and active-high):
- inClk  in  1  clock, all state on rising edge
- inRst  in  1  synchronous active-high reset
- inData  in  N_CH*W  channel k occupies bits [k*W +: W]
- inValid  in  N_CH  per-channel data valid
- outAck  out  N_CH  one-hot, high in the cycle channel k's word is captured (combinational)
- inMode  in  1  0 = FIXED, 1 = ROUND_ROBIN; level, sampled every cycle
- inSel  in  SEL_W  channel index for FIXED mode / RR pointer preset
- inSelLoad  in  1  one-cycle strobe loading inSel
- outSelErr  out  1  one-cycle pulse: inSelLoad with inSel ≥ N_CH
- outData  out  W  registered selected word
- outCh  out  SEL_W  index of channel held in outData
- outValid  out  1  outData/outCh valid
- inReady  in  1  downstream accepts outData when outValid && inReady

## Operation
- State: selReg (SEL_W), rrPtr (SEL_W), output register {outData, outCh, outValid}.
- Grant (combinational): FIXED → grant = selReg, grantValid = inValid[selReg]. ROUND_ROBIN → first k with inValid[k] set, searching rrPtr, rrPtr+1, …, wrapping modulo N_CH; grantValid = |inValid.
- Capture condition: cap = grantValid && (!outValid || inReady).
- On cap: outData ← inData[grant], outCh ← grant, outValid ← 1; outAck = one-hot(grant) same cycle. In ROUND_ROBIN, rrPtr ← (grant+1) mod N_CH (wrap at N_CH, not 2^SEL_W).
- Not cap and outValid && inReady: outValid ← 0, outData/outCh hold.
- Not cap and (!outValid or !inReady): all hold; outAck = 0.
- inSelLoad with inSel < N_CH: selReg ← inSel and rrPtr ← inSel next cycle; grant that cycle uses old values.
- inSelLoad with inSel ≥ N_CH: selReg/rrPtr unchanged, outSelErr = 1 next cycle for one cycle.
- inMode change: new mode applies to the grant in the same cycle; rrPtr retained across FIXED periods.
- FIXED mode never advances rrPtr; ROUND_ROBIN never modifies selReg.

## Timing
- Latency: input word captured at edge t appears on outData at t+1 (1 cycle).
- Throughput: one word per cycle when inReady held high and a grant is valid.
- outData/outCh stable while outValid && !inReady (no overwrite, outAck = 0).
- Reset (inRst high at an edge): outValid=0, outData=0, outCh=0, selReg=0, rrPtr=0, outSelErr=0; outAck=0 while inRst high regardless of inputs. Reset mid-transfer discards the held word.
- inRst has priority over inSelLoad and cap in the same cycle.

## Structure
- Package mux_pkg: mode constants MODE_FIXED=1'b0, MODE_ROUND_ROBIN=1'b1; helper function for wrap-increment modulo N_CH.
- Sub-module rr_arbiter (N_CH): inputs request vector and pointer, outputs one-hot grant, grant index, any-valid; purely combinational. Top holds all registers.

## Test plan
- FIXED, N_CH=4, W=4: load inSel=2, inData ch2=0xA, inValid=4'b0100, inReady=1 → outAck=4'b0100 that cycle; next cycle outValid=1, outData=0xA, outCh=2.
- Backpressure: outValid=1, inReady=0 for 3 cycles with ch2 still valid → outData=0xA held, outAck=0; inReady=1 → new capture next edge.
- ROUND_ROBIN, all inValid=1, ch k data = k+1, inReady=1 → outCh sequence 0,1,2,3,0, outData 1,2,3,4,1.
- ROUND_ROBIN, inValid=4'b1010 → outCh 1,3,1,3; wrap from 3 to 0 skips ch0/ch2.
- N_CH=3: inSelLoad with inSel=3 → outSelErr pulses once, selReg unchanged, output channel unchanged.
- inRst asserted while outValid=1 and inReady=0 → next cycle outValid=0, outData=0, outCh=0, rrPtr=0; RR restarts at ch0.
